// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: operand, MTHI/MTLO and result bundle for the iterative multiply/divide unit.
interface mult_div_unit_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    modport master (output start, op, src_a, src_b, wr_hi, wr_lo, wr_data,
                    input busy, done, div_by_zero, hi, lo);
    modport slave (input start, op, src_a, src_b, wr_hi, wr_lo, wr_data,
                   output busy, done, div_by_zero, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: one-bit-per-cycle MULT/MULTU/DIV/DIVU with HI/LO registers.
module mult_div_unit #(parameter int WIDTH = 32) (
    input logic clk,
    input logic rst_n,
    mult_div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, step, prod;
    logic [WIDTH-1:0] b_q, b_d, hi_q, hi_d, lo_q, lo_d, abs_a, abs_b, quo, rem;
    logic [CW-1:0] cnt_q, cnt_d;
    logic div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;
    logic a_neg, b_neg, div_ok;
    logic [WIDTH:0] mul_sum, div_tr, div_diff;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end
    // Working register holds {partial product, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        a_neg    = ~bus.op[0] & bus.src_a[WIDTH-1];
        b_neg    = ~bus.op[0] & bus.src_b[WIDTH-1];
        abs_a    = a_neg ? -bus.src_a : bus.src_a;
        abs_b    = b_neg ? -bus.src_b : bus.src_b;
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
        div_tr   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff = div_tr - {1'b0, b_q};
        div_ok   = ~div_diff[WIDTH];
        step     = div_q ? {div_ok ? div_diff[WIDTH-1:0] : div_tr[WIDTH-1:0], acc_q[WIDTH-2:0], div_ok}
                         : {mul_sum, acc_q[WIDTH-1:1]};
        prod     = neg_q ? -step : step;
        quo      = neg_q ? -step[WIDTH-1:0] : step[WIDTH-1:0];
        rem      = rneg_q ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];
        state_d  = state_q;
        acc_d    = acc_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dz_d     = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        if (state_q == RUN) begin
            acc_d = step;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
                state_d = DONE;
                hi_d    = div_q ? rem : prod[2*WIDTH-1:WIDTH];
                lo_d    = div_q ? quo : prod[WIDTH-1:0];
            end
        end else if (bus.start) begin
            div_d   = bus.op[1];
            neg_d   = a_neg ^ b_neg;
            rneg_d  = a_neg;
            acc_d   = {{WIDTH{1'b0}}, abs_a};
            b_d     = abs_b;
            cnt_d   = '0;
            dz_d    = bus.op[1] && bus.src_b == '0;
            state_d = dz_d ? DONE : RUN;
        end else begin
            state_d = IDLE;
            hi_d    = bus.wr_hi ? bus.wr_data : hi_q;
            lo_d    = bus.wr_lo ? bus.wr_data : lo_q;
        end
    end
    assign bus.busy        = state_q == RUN;
    assign bus.done        = state_q == DONE;
    assign bus.div_by_zero = dz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit against a 64-bit arithmetic model.
module tb_mult_div_unit;
    localparam int W = 32;
    typedef struct packed {logic [W-1:0] hi; logic [W-1:0] lo; logic dz;} exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    exp_t sb[$];
    logic [W-1:0] m_hi = '0, m_lo = '0, hi_at1, prev_hi;
    always #5 clk = ~clk;
    mult_div_unit_if #(.WIDTH(W)) bus();
    mult_div_unit #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        longint p;
        int q, r;
        e = '0;
        if (o == 2'd0) begin
            p = longint'($signed(a)) * longint'($signed(b));
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (o == 2'd1) begin
            p = longint'({32'b0, a}) * longint'({32'b0, b});
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (b == '0) begin
            e = {m_hi, m_lo, 1'b1};
        end else if (o == 2'd3) begin
            e.lo = a / b;
            e.hi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.lo = 32'h8000_0000;
            e.hi = '0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
            e.lo = q;
            e.hi = r;
        end
        return e;
    endfunction
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.done) begin
            if (sb.size() == 0) check("spurious_done", 1, 0);
            else begin
                e = sb.pop_front();
                check("hi", bus.hi, e.hi);
                check("lo", bus.lo, e.lo);
                check("div_by_zero", bus.div_by_zero, e.dz);
            end
        end else if (bus.div_by_zero) check("dz_without_done", 1, 0);
    end
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit hold, input bit inject);
        exp_t e;
        int n, nb, lat;
        e = model(o, a, b);
        sb.push_back(e);
        m_hi = e.hi;
        m_lo = e.lo;
        lat = (o[1] && b == '0) ? 1 : W + 1;
        bus.start = 1'b1;
        bus.op = o;
        bus.src_a = a;
        bus.src_b = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.wr_hi = 1'b0;
        bus.wr_lo = 1'b0;
        bus.src_a = $urandom;
        bus.src_b = $urandom;
        n = 0;
        nb = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) hi_at1 = bus.hi;
            if (bus.busy) nb++;
            if (inject && n == 5) begin
                bus.start = 1'b1;
                bus.op = 2'b01;
                bus.src_a = 32'd3;
                bus.src_b = 32'd4;
                bus.wr_lo = 1'b1;
                bus.wr_data = 32'hDEAD;
            end
            if (inject && n == 6) begin
                bus.start = 1'b0;
                bus.wr_lo = 1'b0;
            end
        end while (!bus.done && n < 100);
        check("latency", n, lat);
        check("busy_cycles", nb, lat - 1);
        if (!hold) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic mtx(input bit h, input bit l, input logic [W-1:0] d);
        bus.wr_hi = h;
        bus.wr_lo = l;
        bus.wr_data = d;
        @(posedge clk);
        #1;
        bus.wr_hi = 1'b0;
        bus.wr_lo = 1'b0;
        if (h) m_hi = d;
        if (l) m_lo = d;
    endtask
    initial begin
        logic [1:0] o;
        logic [W-1:0] a, b;
        bus.start = 1'b0;
        bus.op = '0;
        bus.src_a = '0;
        bus.src_b = '0;
        bus.wr_hi = 1'b0;
        bus.wr_lo = 1'b0;
        bus.wr_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hi", bus.hi, 0);
        check("rst_lo", bus.lo, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_dz", bus.div_by_zero, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        mtx(1'b1, 1'b0, 32'h12);
        mtx(1'b0, 1'b1, 32'h34);
        check("mthi", bus.hi, 32'h12);
        check("mtlo", bus.lo, 32'h34);
        run_op(2'd3, 32'd100, 32'd0, 1'b0, 1'b0);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
        bus.start = 1'b1;
        bus.op = 2'd1;
        bus.src_a = 32'd5;
        bus.src_b = 32'd6;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_hi", bus.hi, 0);
        check("abort_lo", bus.lo, 0);
        m_hi = '0;
        m_lo = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op(2'd3, 32'd17, 32'd5, 1'b0, 1'b0);
        prev_hi = m_hi;
        bus.wr_hi = 1'b1;
        bus.wr_data = 32'hAA;
        run_op(2'd1, 32'd2, 32'd3, 1'b0, 1'b0);
        check("start_beats_write", hi_at1, prev_hi);
        for (int i = 0; i < 8; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            run_op(o, a, b, 1'b0, 1'b0);
        end
        repeat (2) @(posedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit in the EX stage, beside the ALU.
- Fed by the same two register operands the ALU receives.
- Implements MULT/MULTU/DIV/DIVU (one bit per cycle) and holds results in architectural HI/LO registers.
- Hazard/stall logic uses busy to freeze the pipeline while an operation is in flight.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request new operation; sampled on rising edge
op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
src_a  input  WIDTH  multiplicand / dividend (rs)
src_b  input  WIDTH  multiplier / divisor (rt)
wr_hi  input  1  MTHI write strobe
wr_lo  input  1  MTLO write strobe
wr_data  input  WIDTH  MTHI/MTLO data
busy  output  1  operation in progress
done  output  1  one-cycle pulse, result valid in hi/lo
div_by_zero  output  1  qualifies done: divisor was zero
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (async, rst_n low):
  - State = IDLE.
  - hi = lo = 0; busy = done = div_by_zero = 0.
  - Internal counters and accumulators cleared.
  - Reset asserted mid-operation aborts the operation; no done is produced.
- States:
  - IDLE: start=1 at edge E0 captures op/src_a/src_b -> RUN, busy=1.
  - RUN: one iteration per cycle, WIDTH iterations (edges E1..E_WIDTH). At edge E_WIDTH the sign-corrected result is written to hi/lo -> DONE.
  - DONE: done=1 and busy=0 for exactly one cycle. Next edge: start=1 -> RUN (back-to-back accepted), else -> IDLE.
- Latency: start sampled at E0, done high in the cycle after edge E_WIDTH, i.e. WIDTH+1 edges later.
- busy is high exactly during RUN.
- start while in RUN is ignored; no queueing.
- Multiply: 2*WIDTH-bit product.
  - hi = upper WIDTH bits, lo = lower WIDTH bits.
  - Signed ops run on magnitudes; the product is negated at completion if operand signs differ.
- Divide (restoring):
  - lo = quotient, truncated toward zero; hi = remainder, sign follows the dividend.
  - Signed ops take magnitudes; quotient is negated if signs differ, remainder is negated if the dividend is negative.
  - -2^(WIDTH-1) / -1 gives lo = 0x80000000, hi = 0 (wrap, no trap).
- Divide by zero (src_b = 0 on a DIV/DIVU start):
  - No iterations; next edge goes straight to DONE.
  - done=1 and div_by_zero=1 for that one cycle.
  - hi/lo unchanged.
- div_by_zero is 0 whenever done is 0.
- MTHI/MTLO writes:
  - wr_hi / wr_lo update hi / lo on the edge, only in IDLE or DONE with start=0.
  - Ignored in RUN.
  - If start and a write coincide, start wins and the write is dropped.
  - wr_hi and wr_lo may both be asserted together.
- hi/lo hold their values until the next completion, an accepted write, or reset.
- Internal state is a 2*WIDTH-bit working register, a log2(WIDTH)+1-bit iteration counter, and latched op/sign flags.
  - Operands are not resampled after E0; src_a/src_b may change freely during RUN.

Test Plan:
- MULT src_a=0xFFFFFFFD (-3), src_b=7 -> busy 32 cycles; done on cycle 33 after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then DIV 0xFFFFFFF9 (-7) / 2 with start held high in the DONE cycle -> back-to-back accepted; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100 / 0 with hi=0x12, lo=0x34 preloaded via wr_hi/wr_lo -> done and div_by_zero high the next cycle; busy never set; hi=0x12, lo=0x34.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. During RUN: pulse start with other operands and wr_lo=1 -> no effect on result or timing.
- Start MULTU 5 x 6, deassert rst_n at cycle 10 -> busy, done, hi, lo all 0 immediately. Release reset, start DIVU 17 / 5 -> lo=3, hi=2, done 33 cycles after start.
- In IDLE assert start and wr_hi together (wr_data=0xAA), MULTU 2 x 3 -> write dropped; hi=0, lo=6.
